// File: rtl/mem_master_if.sv
// Core request/response channel and data-memory pins for mem_master.
// The master modport is the initiator; the slave modport is the core plus memory side.
`timescale 1ns/1ps
interface mem_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_w;
   logic [15:0] mem_addr;
   logic [15:0] mem_i0;
   logic [15:0] mem_o0;
   logic        mem_ready;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, mem_o0, mem_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_w, mem_addr, mem_i0
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, mem_o0, mem_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_w, mem_addr, mem_i0
   );
endinterface

// File: rtl/mem_master.sv
// Initiator for the data memory: sequences one load/store per request through
// issue, settle and wait phases and returns one registered response per request.
`timescale 1ns/1ps
module mem_master #(
   parameter logic [15:0] MEM_SIZE = 16'h0100,
   parameter logic [7:0]  TIMEOUT  = 8'd16
) (
   input logic          clk,
   input logic          rst,
   mem_master_if.master bus
);

   typedef enum logic [1:0] {StIdle, StIssue, StSettle, StWait} state_e;

   state_e      state_q, state_d;
   logic        mem_w_q, mem_w_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_i0_q, mem_i0_d;
   logic        wr_q, wr_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  cnt_inc;
   logic        rsp_valid_q, rsp_valid_d;
   logic [15:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;
   logic        req_ready;
   logic        accept;
   logic        in_range;

   assign req_ready = (state_q == StIdle) && bus.mem_ready;
   assign accept    = bus.req_valid && req_ready;
   assign in_range  = bus.req_addr < MEM_SIZE;
   assign cnt_inc   = cnt_q + 8'd1;

   // Out-of-range requests answer directly from IDLE without touching the memory pins.
   always_comb begin
      state_d     = state_q;
      mem_w_d     = mem_w_q;
      mem_addr_d  = mem_addr_q;
      mem_i0_d    = mem_i0_q;
      wr_d        = wr_q;
      cnt_d       = cnt_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (in_range) begin
                  mem_addr_d = bus.req_addr;
                  mem_i0_d   = bus.req_wdata;
                  mem_w_d    = bus.req_write;
                  wr_d       = bus.req_write;
                  cnt_d      = 8'd0;
                  state_d    = StIssue;
               end else begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = 16'h0000;
               end
            end
         end
         StIssue: begin
            mem_w_d = 1'b0;
            state_d = StSettle;
         end
         // Memory may still be deasserting ready from the access; do not look at it yet.
         StSettle: begin
            state_d = StWait;
         end
         StWait: begin
            cnt_d = cnt_inc;
            if (bus.mem_ready) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = wr_q ? mem_i0_q : bus.mem_o0;
               state_d     = StIdle;
            end else if (cnt_inc == TIMEOUT) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = 16'h0000;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         mem_w_q     <= 1'b0;
         mem_addr_q  <= 16'h0000;
         mem_i0_q    <= 16'h0000;
         wr_q        <= 1'b0;
         cnt_q       <= 8'd0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 16'h0000;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_w_q     <= mem_w_d;
         mem_addr_q  <= mem_addr_d;
         mem_i0_q    <= mem_i0_d;
         wr_q        <= wr_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.mem_w     = mem_w_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_i0    = mem_i0_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master against a small word memory that dips ready
// for one cycle after each write and can be held busy to force a timeout.
`timescale 1ns/1ps
module tb_mem_master;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;

   mem_master_if bus ();

   mem_master #(
      .MEM_SIZE (16'h0100),
      .TIMEOUT  (8'd16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Memory model: write sampled at posedge while mem_w is high; ready dips the cycle after.
   logic [15:0] mem [256];
   logic        dip_q;
   logic        hold_low = 1'b0;

   assign bus.mem_ready = !dip_q && !hold_low;
   assign bus.mem_o0    = mem[bus.mem_addr[7:0]];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         dip_q <= 1'b0;
         for (int i = 0; i < 256; i++) mem[i] <= 16'(i) ^ 16'hA5A5;
      end else if (bus.mem_w) begin
         mem[bus.mem_addr[7:0]] <= bus.mem_i0;
         dip_q <= 1'b1;
      end else begin
         dip_q <= 1'b0;
      end
   end

   logic [15:0] last_addr = 16'h0000;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One request; lat counts edges from the accept edge (=1) to the edge raising rsp_valid.
   task automatic txn(input string tag, input logic w, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] exp_d, input logic exp_e, input int exp_lat,
                      input logic stall);
      int lat;
      int wp;
      int guard;
      logic [15:0] exp_addr;
      guard = 0;
      while (!bus.req_ready && guard < 50) begin
         tick();
         guard++;
      end
      check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
      exp_addr = (exp_lat == 1) ? last_addr : a;
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      tick();
      bus.req_valid = 1'b0;
      bus.req_addr  = 16'hDEAD;
      bus.req_wdata = 16'hBEEF;
      if (stall) hold_low = 1'b1;
      lat = 1;
      wp  = bus.mem_w ? 1 : 0;
      while (!bus.rsp_valid && lat < 60) begin
         tick();
         lat++;
         if (bus.mem_w) wp++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " rdata"}, 32'(bus.rsp_rdata), 32'(exp_d));
      check({tag, " err"}, 32'(bus.rsp_err), 32'(exp_e));
      check({tag, " mem_w cycles"}, 32'(wp), (exp_lat == 1) ? 32'd0 : 32'(w));
      check({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(exp_addr));
      last_addr = exp_addr;
      tick();
      check({tag, " pulse width"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, " rdata hold"}, 32'(bus.rsp_rdata), 32'(exp_d));
      if (stall) begin
         hold_low = 1'b0;
         #1;
         check({tag, " back to idle"}, 32'(bus.req_ready), 32'd1);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " mem_w"}, 32'(bus.mem_w), 32'd0);
      check({tag, " mem_addr"}, 32'(bus.mem_addr), 32'd0);
      check({tag, " mem_i0"}, 32'(bus.mem_i0), 32'd0);
      check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, " rsp_rdata"}, 32'(bus.rsp_rdata), 32'd0);
      check({tag, " rsp_err"}, 32'(bus.rsp_err), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [15:0] bb_addr  [3];
      logic [15:0] bb_wdata [3];
      logic        bb_write [3];
      logic [15:0] got [3];
      int          idx;
      int          nrsp;
      int          extra;
      logic        acc;
      logic        prev_v;
      logic        dbl;
      logic        rdy_ok;
      logic        any_err;

      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = 16'h0000;
      bus.req_wdata = 16'h0000;

      // Reset state
      tick();
      tick();
      check_reset_outputs("reset");
      check("reset req_ready", 32'(bus.req_ready), 32'd1);
      rst = 1'b0;
      tick();

      // 1. Store, then 2. loads including a repeat of the same address
      txn("store 10", 1'b1, 16'h0010, 16'h00AB, 16'h00AB, 1'b0, 4, 1'b0);
      txn("load 10", 1'b0, 16'h0010, 16'h0000, 16'h00AB, 1'b0, 4, 1'b0);
      txn("reload 10", 1'b0, 16'h0010, 16'h0000, 16'h00AB, 1'b0, 4, 1'b0);

      // 3. Range boundary: last word is legal, MEM_SIZE and 0xFFFF are not
      txn("oor 100", 1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1, 1, 1'b0);
      txn("load ff", 1'b0, 16'h00FF, 16'h0000, 16'hA55A, 1'b0, 4, 1'b0);
      txn("oor ffff store", 1'b1, 16'hFFFF, 16'h1111, 16'h0000, 1'b1, 1, 1'b0);

      // 4. Memory stays busy: 3 edges to WAIT plus 16 WAIT cycles = 19
      txn("timeout", 1'b0, 16'h0040, 16'h0000, 16'h0000, 1'b1, 19, 1'b1);
      txn("after timeout", 1'b0, 16'h0010, 16'h0000, 16'h00AB, 1'b0, 4, 1'b0);

      // 5a. Reset while mem_w is high (ISSUE)
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 16'h0030;
      bus.req_wdata = 16'h1234;
      tick();
      bus.req_valid = 1'b0;
      check("issue mem_w", 32'(bus.mem_w), 32'd1);
      rst = 1'b1;
      #1;
      check_reset_outputs("rst in issue");
      tick();
      rst = 1'b0;
      tick();

      // 5b. Reset in SETTLE of a store; no response may follow
      txn("store 31", 1'b1, 16'h0031, 16'h5678, 16'h5678, 1'b0, 4, 1'b0);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 16'h0030;
      bus.req_wdata = 16'h1234;
      tick();
      bus.req_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check_reset_outputs("rst in settle");
      tick();
      rst = 1'b0;
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.rsp_valid) extra++;
      end
      check("no rsp after reset", 32'(extra), 32'd0);
      last_addr = 16'h0000;

      // 6. Back-to-back with req_valid held high
      bb_write = '{1'b1, 1'b0, 1'b1};
      bb_addr  = '{16'h0020, 16'h0020, 16'h0021};
      bb_wdata = '{16'h0001, 16'h0000, 16'h0002};
      got      = '{16'h0000, 16'h0000, 16'h0000};
      idx = 0;
      nrsp = 0;
      prev_v = 1'b0;
      dbl = 1'b0;
      rdy_ok = 1'b1;
      any_err = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_write = bb_write[0];
      bus.req_addr  = bb_addr[0];
      bus.req_wdata = bb_wdata[0];
      for (int cyc = 0; cyc < 40 && nrsp < 3; cyc++) begin
         acc = bus.req_valid && bus.req_ready;
         tick();
         if (acc) begin
            idx++;
            if (idx < 3) begin
               bus.req_write = bb_write[idx];
               bus.req_addr  = bb_addr[idx];
               bus.req_wdata = bb_wdata[idx];
            end else begin
               bus.req_valid = 1'b0;
            end
         end
         if (bus.rsp_valid) begin
            if (nrsp < 3) got[nrsp] = bus.rsp_rdata;
            nrsp++;
            if (prev_v) dbl = 1'b1;
            if (bus.rsp_err) any_err = 1'b1;
            if (!bus.req_ready) rdy_ok = 1'b0;
         end
         prev_v = bus.rsp_valid;
      end
      bus.req_valid = 1'b0;
      tick();
      if (bus.rsp_valid) nrsp++;
      check("b2b accepts", 32'(idx), 32'd3);
      check("b2b responses", 32'(nrsp), 32'd3);
      check("b2b rsp0", 32'(got[0]), 32'h0001);
      check("b2b rsp1", 32'(got[1]), 32'h0001);
      check("b2b rsp2", 32'(got[2]), 32'h0002);
      check("b2b single pulses", 32'(dbl), 32'd0);
      check("b2b no err", 32'(any_err), 32'd0);
      check("b2b ready at rsp", 32'(rdy_ok), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
